sme_host: RTL and testbench
===========================

# sme_host

Host-side driver for the string-matching engine: it owns a 32-byte string buffer and an 8-byte pattern buffer and replays them onto the engine's byte-serial input protocol (`chardata`, `isstring`, `ispattern`). It then waits for the engine's `valid`, captures `match`/`match_index`, and reports one result per job. It sits between the test/control logic and the matcher, and is the initiator side of that interface.

## Interface
Parameters:
- `STR_MAX`, 32: string buffer depth in bytes.
- `PAT_MAX`, 8: pattern buffer depth in bytes.
- `TIMEOUT`, 64: cycles to wait in WAIT for `valid` before aborting; range 2..255.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  buffer write strobe.
- `wr_sel`  in  1  0 selects the string buffer, 1 selects the pattern buffer.
- `wr_addr`  in  5  byte address; for the pattern buffer only bits [2:0] are used.
- `wr_data`  in  8  byte to write.
- `str_len`  in  6  string length, sampled on an accepted `start`.
- `pat_len`  in  4  pattern length, sampled on an accepted `start`.
- `send_str`  in  1  when 1, the job resends the string before the pattern.
- `start`  in  1  job request.
- `busy`  out  1  high in every state except IDLE.
- `chardata`  out  8  byte driven to the engine.
- `isstring`  out  1  marks a string byte on `chardata`.
- `ispattern`  out  1  marks a pattern byte on `chardata`.
- `valid`  in  1  result strobe from the engine.
- `match`  in  1  engine match flag.
- `match_index`  in  5  engine match position.
- `done`  out  1  one-cycle pulse: a job's result is available.
- `res_match`  out  1  captured match flag.
- `res_index`  out  5  captured match index.
- `timeout`  out  1  qualifies `done`: the job was aborted with no `valid`.

## Operation
- Reset: FSM goes to IDLE. `busy`, `chardata`, `isstring`, `ispattern`, `done`, `res_match`, `res_index` and `timeout` are all 0. The `str_sent` flag clears. Buffer contents are not cleared.
- Writes: accepted only when `busy` is 0. A write while `busy` is 1 is dropped.
- Write and start together: if `wr_en` and `start` are both asserted in IDLE, the write is performed and the job launches. The job sees the pre-write data at that address only if that byte has already been transmitted; otherwise it sees the new data.
- `start` acceptance: honoured only in IDLE. On acceptance the block latches the lengths:
  - `str_len` is clamped to 32 when it is 0 or greater than 32.
  - `pat_len` is clamped to 8 when it is 0 or greater than 8.
- State after `start`:
  - STR if `send_str` is 1 or `str_sent` is 0. A pattern job before any string forces a string send.
  - PAT otherwise.
- STR: for index i = 0..str_len-1, one byte per cycle: `chardata` = sbuf[i], `isstring` = 1. After the last byte go straight to PAT with no gap cycle. `str_sent` sets.
- PAT: for i = 0..pat_len-1: `chardata` = pbuf[i], `ispattern` = 1. After the last byte go to WAIT.
- WAIT: `isstring`, `ispattern` and `chardata` are 0. The wait counter starts at 0.
  - `valid` = 1: capture `match` and `match_index`, go to DONE.
  - Counter reaches TIMEOUT-1 with no `valid`: go to DONE with the timeout path selected.
  - `valid` in the same cycle the counter reaches TIMEOUT-1: `valid` wins.
- DONE, lasting one cycle:
  - `done` = 1.
  - On a valid result: `timeout` = 0, `res_match`/`res_index` = the captured values.
  - On timeout: `timeout` = 1, `res_match` = 0, `res_index` = 0.
  - Then return to IDLE.
- Result holding: `res_match`, `res_index` and `timeout` hold their values until the next DONE.
- `valid` outside WAIT is ignored.
- Counters: the 6-bit byte index resets on every state entry. The 8-bit wait counter saturates.

## Timing
- All outputs are registered.
- `start` sampled at edge T → first string byte valid in cycle T+1.
- Last string byte in cycle T+L → first pattern byte in cycle T+L+1.
- WAIT entered in the cycle after the last pattern byte. `valid` sampled at edge V → `done` high in cycle V+1.
- `busy` rises in cycle T+1 and falls in the cycle after the `done` pulse. `start` is accepted again from that cycle.
- Minimum job length, pattern-only with P=1 and `valid` in the first WAIT cycle: 3 cycles from `start` to `done`.
- Reset asserted mid-job: at the next edge the state is IDLE and all outputs are 0, including `isstring`/`ispattern`. No partial `done` is produced.

## Test plan
- Load sbuf = "ab cd" (`str_len` 5) and pbuf = "cd" (`pat_len` 2), `send_str` = 1, `start`. Required: `isstring` high exactly 5 cycles carrying 61,62,20,63,64. `ispattern` high the next 2 cycles carrying 63,64. Bench engine returns `valid` with `match` = 1, `match_index` = 3 → `done` pulse with `res_match` = 1, `res_index` = 3.
- Back-to-back pattern job with `send_str` = 0, pbuf = "^a", `pat_len` 2. Required: no `isstring` cycles; `ispattern` for 2 cycles; result `match` = 0 is reported as `res_match` = 0.
- First job after reset with `send_str` = 0. Required: the string is still sent (forced STR).
- Engine never responds, `TIMEOUT` = 64. Required: `done` = 1 with `timeout` = 1 and `res_index` = 0, exactly 64 cycles after WAIT entry.
- `wr_en` and `start` pulsed while `busy` = 1. Required: buffer contents unchanged and no second job. Then `str_len` = 0 with `pat_len` = 9. Required: 32 string bytes and 8 pattern bytes are sent.
- Assert `reset` in the 3rd string cycle. Required: the next cycle shows `isstring` = 0 and `busy` = 0, and no `done` pulse ever follows.

Source files
------------

// File: rtl/sme_host.sv
// Host-side driver for the string-matching engine: buffers a string and a
// pattern, replays them byte-serially, then reports the engine's result.
module sme_host #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       wr_en_i,
    input  logic       wr_sel_i,
    input  logic [4:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic [5:0] str_len_i,
    input  logic [3:0] pat_len_i,
    input  logic       send_str_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic [7:0] chardata_o,
    output logic       isstring_o,
    output logic       ispattern_o,
    input  logic       valid_i,
    input  logic       match_i,
    input  logic [4:0] match_index_i,
    output logic       done_o,
    output logic       res_match_o,
    output logic [4:0] res_index_o,
    output logic       timeout_o
);

    localparam int SAW = $clog2(STR_MAX);
    localparam int PAW = $clog2(PAT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STR,
        S_PAT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [7:0] sbuf_q [STR_MAX];
    logic [7:0] pbuf_q [PAT_MAX];
    logic [5:0] idx_q;
    logic [5:0] slen_q;
    logic [3:0] plen_q;
    logic [7:0] wcnt_q;
    logic       str_sent_q;
    logic       busy_q;
    logic       isstring_q;
    logic       ispattern_q;
    logic [7:0] chardata_q;
    logic       done_q;
    logic       res_match_q;
    logic [4:0] res_index_q;
    logic       timeout_q;

    logic       wr_ok;
    logic [5:0] slen_d;
    logic [3:0] plen_d;
    logic [7:0] sbyte0;
    logic [7:0] pbyte0;

    // Byte 0 is read on the launch edge, so a coincident write must bypass
    always_comb begin
        wr_ok  = wr_en_i && !busy_q;
        slen_d = str_len_i;
        if (str_len_i == 6'd0 || str_len_i > 6'(STR_MAX))
            slen_d = 6'(STR_MAX);
        plen_d = pat_len_i;
        if (pat_len_i == 4'd0 || pat_len_i > 4'(PAT_MAX))
            plen_d = 4'(PAT_MAX);
        sbyte0 = sbuf_q[0];
        if (wr_ok && !wr_sel_i && wr_addr_i[SAW-1:0] == '0)
            sbyte0 = wr_data_i;
        pbyte0 = pbuf_q[0];
        if (wr_ok && wr_sel_i && wr_addr_i[PAW-1:0] == '0)
            pbyte0 = wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            if (wr_sel_i)
                pbuf_q[wr_addr_i[PAW-1:0]] <= wr_data_i;
            else
                sbuf_q[wr_addr_i[SAW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            slen_q      <= '0;
            plen_q      <= '0;
            wcnt_q      <= '0;
            str_sent_q  <= 1'b0;
            busy_q      <= 1'b0;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            chardata_q  <= '0;
            done_q      <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        slen_q <= slen_d;
                        plen_q <= plen_d;
                        busy_q <= 1'b1;
                        idx_q  <= 6'd1;
                        if (send_str_i || !str_sent_q) begin
                            state_q    <= S_STR;
                            isstring_q <= 1'b1;
                            chardata_q <= sbyte0;
                        end else begin
                            state_q     <= S_PAT;
                            ispattern_q <= 1'b1;
                            chardata_q  <= pbyte0;
                        end
                    end
                end
                S_STR: begin
                    if (idx_q == slen_q) begin
                        state_q     <= S_PAT;
                        isstring_q  <= 1'b0;
                        ispattern_q <= 1'b1;
                        chardata_q  <= pbuf_q[0];
                        idx_q       <= 6'd1;
                        str_sent_q  <= 1'b1;
                    end else begin
                        chardata_q <= sbuf_q[idx_q[SAW-1:0]];
                        idx_q      <= idx_q + 6'd1;
                    end
                end
                S_PAT: begin
                    if (idx_q == {2'b00, plen_q}) begin
                        state_q     <= S_WAIT;
                        ispattern_q <= 1'b0;
                        chardata_q  <= '0;
                        idx_q       <= '0;
                        wcnt_q      <= '0;
                    end else begin
                        chardata_q <= pbuf_q[idx_q[PAW-1:0]];
                        idx_q      <= idx_q + 6'd1;
                    end
                end
                S_WAIT: begin
                    if (valid_i) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        res_match_q <= match_i;
                        res_index_q <= match_index_i;
                        timeout_q   <= 1'b0;
                    end else if (wcnt_q == 8'(TIMEOUT - 1)) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        res_match_q <= 1'b0;
                        res_index_q <= '0;
                        timeout_q   <= 1'b1;
                    end else if (wcnt_q != 8'hFF) begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign chardata_o  = chardata_q;
    assign isstring_o  = isstring_q;
    assign ispattern_o = ispattern_q;
    assign done_o      = done_q;
    assign res_match_o = res_match_q;
    assign res_index_o = res_index_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sme_host.sv
// Bench for sme_host: per-cycle expected-output queue built from the
// buffer contents and job rules, plus literal checks on captured streams.
module tb_sme_host;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, wr_sel;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic       send_str, start;
    logic       busy;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       valid, match;
    logic [4:0] match_index;
    logic       done, res_match;
    logic [4:0] res_index;
    logic       timeout;

    always #5 clk = ~clk;

    sme_host #(.TIMEOUT(TO)) dut (
        .clk_i(clk),
        .reset_i(reset),
        .wr_en_i(wr_en),
        .wr_sel_i(wr_sel),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .str_len_i(str_len),
        .pat_len_i(pat_len),
        .send_str_i(send_str),
        .start_i(start),
        .busy_o(busy),
        .chardata_o(chardata),
        .isstring_o(isstring),
        .ispattern_o(ispattern),
        .valid_i(valid),
        .match_i(match),
        .match_index_i(match_index),
        .done_o(done),
        .res_match_o(res_match),
        .res_index_o(res_index),
        .timeout_o(timeout)
    );

    typedef struct packed {
        logic       busy;
        logic       isstr;
        logic       ispat;
        logic [7:0] ch;
        logic       done;
        logic       rm;
        logic [4:0] ri;
        logic       to;
    } rec_t;

    rec_t       expq[$];
    logic [7:0] mS[32];
    logic [7:0] mP[8];
    bit         m_sent;
    logic       h_rm;
    logic [4:0] h_ri;
    logic       h_to;
    logic [7:0] slog[$];
    logic [7:0] plog[$];
    int         bcnt;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         chk_en = 0;

    function automatic rec_t mk(logic b, logic s, logic p,
                                logic [7:0] c, logic d);
        rec_t r;
        r.busy  = b;
        r.isstr = s;
        r.ispat = p;
        r.ch    = c;
        r.done  = d;
        r.rm    = h_rm;
        r.ri    = h_ri;
        r.to    = h_to;
        return r;
    endfunction

    always @(negedge clk) begin
        rec_t e;
        rec_t a;
        if (chk_en) begin
            a = {busy, isstring, ispattern, chardata,
                 done, res_match, res_index, timeout};
            if (expq.size() > 0) e = expq.pop_front();
            else e = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            if (isstring) slog.push_back(chardata);
            if (ispattern) plog.push_back(chardata);
            if (busy) bcnt++;
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle t=%0t got %h want %h", $time, a, e);
            end
        end
    end

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic wr(logic sel, logic [4:0] a, logic [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
        if (sel) mP[a[2:0]] = d;
        else mS[a] = d;
    endtask

    function automatic logic [63:0] pack(input logic [7:0] q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = {v[55:0], q[i]};
        return v;
    endfunction

    task automatic run_job(input bit sstr, input int sl, input int pl,
                           input int vk, input bit m,
                           input logic [4:0] mi, input bit poke,
                           input bit sw, input logic [7:0] sd);
        int ns, np, n, nw;
        bit ds;
        ns = (sl == 0 || sl > 32) ? 32 : sl;
        np = (pl == 0 || pl > 8) ? 8 : pl;
        ds = sstr || !m_sent;
        slog.delete();
        plog.delete();
        bcnt = 0;
        str_len  = 6'(sl);
        pat_len  = 4'(pl);
        send_str = sstr;
        start    = 1'b1;
        if (sw) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b1;
            wr_addr = 5'd0;
            wr_data = sd;
            mP[0]   = sd;
        end
        @(posedge clk);
        #1 start = 1'b0;
        wr_en = 1'b0;
        if (ds)
            for (int i = 0; i < ns; i++)
                expq.push_back(mk(1'b1, 1'b1, 1'b0, mS[i], 1'b0));
        for (int j = 0; j < np; j++)
            expq.push_back(mk(1'b1, 1'b0, 1'b1, mP[j], 1'b0));
        m_sent = m_sent | ds;
        nw = (vk < 0) ? TO : vk + 1;
        for (int k = 0; k < nw; k++)
            expq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
        h_rm = (vk >= 0) ? m : 1'b0;
        h_ri = (vk >= 0) ? mi : 5'd0;
        h_to = (vk < 0);
        expq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1));
        n = (ds ? ns : 0) + np + vk;
        if (poke) begin
            wr_en = 1'b1;
            wr_sel = 1'b0;
            wr_addr = 5'd1;
            wr_data = 8'h5A;
            start = 1'b1;
            valid = 1'b1;
            match = 1'b1;
            match_index = 5'd31;
            @(posedge clk);
            #1 wr_en = 1'b0;
            start = 1'b0;
            valid = 1'b0;
            match = 1'b0;
            match_index = 5'd0;
            n--;
        end
        if (vk >= 0) begin
            repeat (n) @(posedge clk);
            #1 valid = 1'b1;
            match = m;
            match_index = mi;
            @(posedge clk);
            #1 valid = 1'b0;
            match = 1'b0;
            match_index = 5'd0;
        end
        for (int c = 0; c < 300 && expq.size() > 0; c++)
            @(negedge clk);
        chk("drain", 64'(expq.size()), 64'd0);
        expq.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] s5[5];
        s5 = '{8'h61, 8'h62, 8'h20, 8'h63, 8'h64};
        reset = 1'b1;
        wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
        str_len = 0; pat_len = 0; send_str = 0; start = 0;
        valid = 0; match = 0; match_index = 0;
        m_sent = 0; h_rm = 0; h_ri = 0; h_to = 0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++)
            wr(1'b0, 5'(i), (i < 5) ? s5[i] : 8'(8'hA0 + i));
        for (int j = 0; j < 8; j++)
            wr(1'b1, 5'(j), (j == 0) ? 8'h63 :
               (j == 1) ? 8'h64 : 8'(8'hB0 + j));

        // first job after reset, send_str=0: string forced
        run_job(0, 5, 2, 0, 1, 5'd3, 0, 0, 8'h00);
        chk("forced_str_len", 64'(slog.size()), 64'd5);
        chk("forced_str", pack(slog), 64'h6162206364);

        run_job(1, 5, 2, 2, 1, 5'd3, 0, 0, 8'h00);
        chk("j1_str", pack(slog), 64'h6162206364);
        chk("j1_pat", pack(plog), 64'h6364);
        chk("j1_match", 64'(res_match), 64'd1);
        chk("j1_index", 64'(res_index), 64'd3);

        wr(1'b1, 5'd0, 8'h5E);
        wr(1'b1, 5'd1, 8'h61);
        run_job(0, 5, 2, 0, 0, 5'd7, 0, 0, 8'h00);
        chk("j2_nostr", 64'(slog.size()), 64'd0);
        chk("j2_pat", pack(plog), 64'h5E61);
        chk("j2_match", 64'(res_match), 64'd0);

        run_job(0, 5, 1, -1, 0, 5'd0, 0, 0, 8'h00);
        chk("to_flag", 64'(timeout), 64'd1);
        chk("to_index", 64'(res_index), 64'd0);

        // valid on the last WAIT cycle beats the timeout
        run_job(0, 5, 1, TO - 1, 1, 5'd9, 0, 0, 8'h00);
        chk("late_to", 64'(timeout), 64'd0);
        chk("late_idx", 64'(res_index), 64'd9);

        run_job(1, 5, 2, 1, 0, 5'd2, 1, 0, 8'h00);
        run_job(1, 0, 9, 0, 1, 5'd17, 0, 0, 8'h00);
        chk("clamp_str", 64'(slog.size()), 64'd32);
        chk("clamp_pat", 64'(plog.size()), 64'd8);
        if (slog.size() > 1)
            chk("drop_wr", 64'(slog[1]), 64'h62);

        run_job(0, 5, 1, 0, 1, 5'd4, 0, 1, 8'h77);
        chk("min_busy", 64'(bcnt), 64'd3);
        chk("wr_start", pack(plog), 64'h77);

        slog.delete();
        str_len = 6'd5;
        pat_len = 4'd2;
        send_str = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3; i++)
            expq.push_back(mk(1'b1, 1'b1, 1'b0, mS[i], 1'b0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        expq.delete();
        h_rm = 0; h_ri = 0; h_to = 0; m_sent = 0;
        chk("mid_rst_isstr", 64'(isstring), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (80) @(posedge clk);
        #1;
        chk("mid_rst_strn", 64'(slog.size()), 64'd3);

        run_job(0, 3, 1, 0, 1, 5'd1, 0, 0, 8'h00);
        chk("post_rst_forced", 64'(slog.size()), 64'd3);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
